// File: rtl/mode_select_ctrl.sv
// Two-row mode menu: debounced buttons move a cursor and lock SCORE/TIME, plus a highlight-box pixel overlay.
// Optional build macro CURSOR_BLINK_EN blinks the highlight box while in MENU.
module mode_select_ctrl #(
    parameter int unsigned DEB_CYCLES = 250000,
    parameter int unsigned CHAR_H     = 40,
    parameter int unsigned BLINK_DIV  = 12500000,
    parameter logic [11:0] TEXT_RGB   = 12'hFFF,
    parameter logic [11:0] HL_RGB     = 12'h00F,
    parameter logic [11:0] LOCK_RGB   = 12'h0F0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_sel,
    input  logic [9:0]  start_x,
    input  logic [9:0]  start_y,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        text_on,
    input  logic        game_over,
    output logic        mode,
    output logic        mode_valid,
    output logic [11:0] rgb
);
    // state  | meaning
    // MENU   | cursor follows up/down, select locks the cursor row as mode
    // LOCKED | mode held and valid, buttons ignored until game_over
    typedef enum logic {MENU = 1'b0, LOCKED = 1'b1} state_t;

    localparam int unsigned DCW = $clog2(DEB_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_TC = DCW'(DEB_CYCLES - 1);

    logic [2:0]     btn_raw, meta, sync, acc, armed, rise;
    logic [DCW-1:0] cnt [3];
    logic           up_ev, dn_ev, sel_ev;

    assign btn_raw = {btn_sel, btn_down, btn_up};

    // A button is armed only after a stable low, so one held through reset stays silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= '0;
            sync  <= '0;
            acc   <= '0;
            armed <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            meta <= btn_raw;
            sync <= meta;
            for (int i = 0; i < 3; i++) begin
                if (!armed[i]) begin
                    if (sync[i]) cnt[i] <= '0;
                    else if (cnt[i] == DEB_TC) begin
                        armed[i] <= 1'b1;
                        cnt[i]   <= '0;
                    end else cnt[i] <= cnt[i] + 1'b1;
                end else if (sync[i] == acc[i]) cnt[i] <= '0;
                else if (cnt[i] == DEB_TC) begin
                    acc[i] <= sync[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rise = '0;
        for (int i = 0; i < 3; i++)
            rise[i] = armed[i] & sync[i] & ~acc[i] & (cnt[i] == DEB_TC);
    end

    assign up_ev  = rise[0];
    assign dn_ev  = rise[1];
    assign sel_ev = rise[2];

    state_t state, state_nx;
    logic   cursor, cursor_nx, mode_r, mode_nx, move;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MENU;
            cursor <= 1'b0;
            mode_r <= 1'b0;
        end else begin
            state  <= state_nx;
            cursor <= cursor_nx;
            mode_r <= mode_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cursor_nx = cursor;
        mode_nx   = mode_r;
        move      = 1'b0;
        case (state)
            MENU: begin
                if (sel_ev) begin
                    state_nx = LOCKED;
                    mode_nx  = cursor;
                end else if (up_ev ^ dn_ev) begin
                    cursor_nx = dn_ev;
                    move      = 1'b1;
                end
            end
            LOCKED: if (game_over) state_nx = MENU;
            default: state_nx = MENU;
        endcase
    end

    assign mode       = mode_r;
    assign mode_valid = (state == LOCKED);

    logic box_vis;
`ifdef CURSOR_BLINK_EN
    localparam int unsigned BCW = $clog2(BLINK_DIV + 1);
    localparam logic [BCW-1:0] BLINK_TC = BCW'(BLINK_DIV - 1);
    logic [BCW-1:0] blink_cnt;
    logic           blink_vis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (state == LOCKED || move) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (blink_cnt == BLINK_TC) begin
            blink_cnt <= '0;
            blink_vis <= ~blink_vis;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign box_vis = blink_vis | (state == LOCKED);
`else
    assign box_vis = 1'b1;
`endif

    // Bounds are 11 bits wide; a top bound past 1023 disables the box instead of wrapping.
    logic [10:0] x_lo, x_hi, row_y, y_lo, y_hi, px, py;
    logic        in_box;
    logic [11:0] rgb_nx;

    always_comb begin
        px     = {1'b0, x};
        py     = {1'b0, y};
        x_lo   = {1'b0, start_x} + 11'd36;
        x_hi   = {1'b0, start_x} + 11'd207;
        row_y  = {1'b0, start_y} + (cursor ? 11'd180 : 11'd100);
        y_lo   = row_y - 11'd4;
        y_hi   = row_y + 11'(CHAR_H) + 11'd3;
        in_box = !x_hi[10] && !y_hi[10] && (px >= x_lo) && (px <= x_hi)
                 && (py >= y_lo) && (py <= y_hi);
        rgb_nx = 12'h000;
        if (!video_on)            rgb_nx = 12'h000;
        else if (text_on)         rgb_nx = TEXT_RGB;
        else if (in_box && box_vis) rgb_nx = (state == LOCKED) ? LOCK_RGB : HL_RGB;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb <= 12'h000;
        else        rgb <= rgb_nx;
    end

endmodule

// File: doc/mode_select_ctrl.md
MODE_SELECT_CTRL -- requirements
Module: mode_select_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 250000, is the number of cycles a synchronized button level must hold before it is accepted (10 ms at 25 MHz).
REQ-002 Parameter CHAR_H, default 40, is the glyph height in pixels used for highlight-box height.
REQ-003 Parameter BLINK_DIV, default 12500000, is the cursor blink half-period in cycles.
REQ-004 Parameter TEXT_RGB, default 12'hFFF, is the text colour.
REQ-005 Parameter HL_RGB, default 12'h00F, is the highlight-box colour in MENU state.
REQ-006 Parameter LOCK_RGB, default 12'h0F0, is the highlight-box colour in LOCKED state.
REQ-007 Port clk, input, 1 bit, is the pixel clock and the only clock; one clock, all state on its rising edge.
REQ-008 Port rst_n, input, 1 bit, is the asynchronous active-low reset.
REQ-009 Ports btn_up, btn_down and btn_sel, input, 1 bit each, are raw asynchronous push buttons, active-high.
REQ-010 Ports start_x and start_y, input, 10 bits each, give the menu origin; they are the same values fed to the menu text renderer.
REQ-011 Ports x and y, input, 10 bits each, give the current pixel coordinate.
REQ-012 Port video_on, input, 1 bit, is high in the visible region.
REQ-013 Port text_on, input, 1 bit, is the menu text renderer display bit for (x, y).
REQ-014 Port game_over, input, 1 bit, is a one-cycle pulse that returns the block to the menu.
REQ-015 Port mode, output, 1 bit, is the locked mode: 0 = SCORE, 1 = TIME.
REQ-016 Port mode_valid, output, 1 bit, is high while a mode is locked.
REQ-017 Port rgb, output, 12 bits, is the registered pixel colour.

Function
REQ-018 Each button SHALL pass a 2-flop synchronizer, then a per-button debounce counter that reloads on any change of the synchronized level; the accepted level updates when the counter reaches DEB_CYCLES-1.
REQ-019 An accepted 0->1 transition SHALL produce exactly one single-cycle event (up_ev, dn_ev, sel_ev); a held button produces no further events.
REQ-020 The FSM SHALL have two states, MENU and LOCKED, and a 1-bit cursor (0 = SCORE row, 1 = TIME row).
REQ-021 In MENU, up_ev SHALL set cursor=0 and dn_ev SHALL set cursor=1; the cursor saturates and does not wrap.
REQ-022 In MENU, up_ev and dn_ev in the same cycle SHALL be ignored.
REQ-023 In MENU, sel_ev SHALL take priority over up_ev/dn_ev in the same cycle; the next edge gives state=LOCKED, mode=current cursor, mode_valid=1.
REQ-024 In LOCKED, all button events SHALL be ignored.
REQ-025 In LOCKED, game_over SHALL return the FSM to MENU with mode_valid=0 on the next edge; mode and cursor are held.
REQ-026 game_over SHALL be ignored in MENU.
REQ-027 Highlight box geometry: row_y = start_y+100 for cursor 0, start_y+180 for cursor 1; box = x in [start_x+36, start_x+207] and y in [row_y-4, row_y+CHAR_H+3].
REQ-028 Box comparisons SHALL use 11-bit unsigned arithmetic with no wrap; any bound at or above 1024 never matches.
REQ-029 rgb SHALL have a latency of one cycle and be selected in this priority: !video_on gives 0; text_on gives TEXT_RGB; in box and box visible gives HL_RGB (MENU) or LOCK_RGB (LOCKED); otherwise 0.

Reset
REQ-030 While rst_n=0, the following SHALL hold regardless of clk: state=MENU, cursor=0, mode=0, mode_valid=0, rgb=0, synchronizers, debounce counters and accepted levels all 0, blink counter 0, blink phase visible.
REQ-031 Reset asserted mid-debounce or while LOCKED SHALL discard all pending events.
REQ-032 After reset, a button already held at release SHALL produce no event until it is released and pressed again.

Configuration
REQ-033 With CURSOR_BLINK_EN defined, in MENU the box visibility SHALL toggle every BLINK_DIV cycles; a cursor move SHALL clear the counter and force the visible phase; in LOCKED the box is always visible.
REQ-034 Without CURSOR_BLINK_EN, the box SHALL always be visible and no blink counter is synthesized.

Verification (DEB_CYCLES=4, BLINK_DIV=8, start_x=200, start_y=100)
REQ-035 Press btn_down for 10 cycles, release, then press btn_sel -> cursor=1, mode=1, mode_valid=1 one cycle after sel_ev.
REQ-036 A 2-cycle glitch on btn_up -> no event, cursor unchanged.
REQ-037 Debounced btn_up and btn_down accepted in the same cycle -> cursor unchanged; btn_sel with btn_down in the same cycle -> mode=0.
REQ-038 LOCKED, press btn_up -> mode held; game_over pulse -> mode_valid=0 next cycle; pixel (300,280) with text_on=0 -> rgb=HL_RGB.
REQ-039 Cursor 0, pixel (236,196), video_on=1: text_on=0 -> rgb=12'h00F one cycle later; text_on=1 -> 12'hFFF; video_on=0 -> 12'h000.
REQ-040 CURSOR_BLINK_EN defined, in MENU: box pixel goes dark after 8 cycles and returns after 16; rst_n pulsed mid-blink -> rgb=0 immediately.
